// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// error flags and a choice of first-word-fall-through or registered read.
module fifo_flagged #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       ren,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] COUNT_AE   = CW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  // Elaboration-time guard against parameter combinations the logic cannot honour
  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_flagged: DEPTH must be at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_chk_af
    $error("fifo_flagged: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_chk_ae
    $error("fifo_flagged: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [PW-1:0]    wptr_next;
  logic [PW-1:0]    rptr_next;

  // Status flags are pure decodes of the occupancy so none of them lags count
  assign full         = (count == COUNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= COUNT_AF);
  assign almost_empty = (count <= COUNT_AE);

  // A full FIFO refuses writes even if a read frees a slot this cycle, and an
  // empty FIFO refuses reads even if a write lands this cycle
  assign wr_acc = wen & ~full;
  assign rd_acc = ren & ~empty;

  // Pointers wrap by explicit compare because DEPTH need not be a power of two
  assign wptr_next = (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
  assign rptr_next = (rptr == PTR_LAST) ? '0 : rptr + PW'(1);

  // Storage array; deliberately not reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping; reset throws away everything at once
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr_next;
      end
      if (rd_acc) begin
        rptr <= rptr_next;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new rejection in the same cycle wins over clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen & ~wr_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (ren & ~rd_acc) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is presented directly; forced to zero while empty so
    // stale or uninitialised storage never shows on the output
    always_comb begin
      data_out   = empty ? '0 : mem[rptr];
      data_valid = ~empty;
    end
  end else begin : g_registered
    // Registered read: popped word appears for exactly one cycle after the
    // accepted read, and data_out keeps the last word in between
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else if (rd_acc) begin
        data_out   <= mem[rptr];
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flagged.sv
// tb_fifo_flagged: drives a first-word-fall-through and a registered-read
// instance (both DEPTH=5) with identical stimulus and compares them against
// a queue-based reference model of the FIFO behaviour.
module tb_fifo_flagged;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wen = 1'b0;
  logic             ren = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0] dout_f, dout_r;
  logic             valid_f, valid_r;
  logic             full_f, full_r, empty_f, empty_r;
  logic             af_f, af_r, ae_f, ae_r;
  logic [CW-1:0]    count_f, count_r;
  logic             ovf_f, ovf_r, unf_f, unf_r;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic [WIDTH-1:0] m_dout_r = '0;
  bit               m_valid_r = 0;

  fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(dout_f), .data_valid(valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
    .clk(clk), .rst(rst), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(dout_r), .data_valid(valid_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
    .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
  );

  // free-running clock
  always #5 clk = ~clk;

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // advance the reference model by one clock edge using pre-edge state
  task automatic modelStep(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd, input bit clr);
    int  n;
    bit  wacc, racc;
    if (r) begin
      model_q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_dout_r = '0;
      m_valid_r = 0;
      return;
    end
    n    = model_q.size();
    wacc = w && (n < DEPTH);
    racc = rd && (n > 0);
    if (racc) begin
      m_dout_r  = model_q.pop_front();
      m_valid_r = 1;
    end else begin
      m_valid_r = 0;
    end
    if (wacc) model_q.push_back(d);
    if (w && !wacc) m_ovf = 1;
    else if (clr)   m_ovf = 0;
    if (rd && !racc) m_unf = 1;
    else if (clr)    m_unf = 0;
  endtask

  // compare both instances against the model just after the edge
  task automatic checkAll(input string phase);
    int n;
    n = model_q.size();
    checkOutput({phase, ":count"},     32'(count_f), 32'(n));
    checkOutput({phase, ":count_r"},   32'(count_r), 32'(n));
    checkOutput({phase, ":full"},      32'(full_f),  32'(n == DEPTH));
    checkOutput({phase, ":empty"},     32'(empty_f), 32'(n == 0));
    checkOutput({phase, ":afull"},     32'(af_f),    32'(n >= AF));
    checkOutput({phase, ":aempty"},    32'(ae_f),    32'(n <= AE));
    checkOutput({phase, ":overflow"},  32'(ovf_f),   32'(m_ovf));
    checkOutput({phase, ":underflow"}, 32'(unf_f),   32'(m_unf));
    checkOutput({phase, ":ovf_r"},     32'(ovf_r),   32'(m_ovf));
    checkOutput({phase, ":valid_fwft"},32'(valid_f), 32'(n > 0));
    if (n > 0) checkOutput({phase, ":dout_fwft"}, 32'(dout_f), 32'(model_q[0]));
    checkOutput({phase, ":valid_reg"}, 32'(valid_r), 32'(m_valid_r));
    checkOutput({phase, ":dout_reg"},  32'(dout_r),  32'(m_dout_r));
  endtask

  // drive one cycle of inputs, clock it, update the model and check
  task automatic applyStimulus(input string phase, input bit r, input bit w,
                               input logic [WIDTH-1:0] d, input bit rd, input bit clr);
    rst = r; wen = w; data_in = d; ren = rd; clr_err = clr;
    @(posedge clk);
    modelStep(r, w, d, rd, clr);
    #1;
    checkAll(phase);
  endtask

  initial begin
    int writes;
    bit w, rd;
    @(negedge clk);

    // reset state
    applyStimulus("reset", 1, 0, 8'h00, 0, 0);
    applyStimulus("reset", 1, 0, 8'h00, 0, 0);
    applyStimulus("idle",  0, 0, 8'h00, 0, 0);

    // fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 0, 1, 8'(8'hA0 + i), 0, 0);
    applyStimulus("overflow", 0, 1, 8'hA5, 0, 0);

    // drain in order, extra read, clear errors
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 0, 0, 8'h00, 1, 0);
    applyStimulus("underflow", 0, 0, 8'h00, 1, 0);
    applyStimulus("clr_err",   0, 0, 8'h00, 0, 1);

    // simultaneous read+write at full and at empty
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill2", 0, 1, 8'(8'hB0 + i), 0, 0);
    applyStimulus("rw_full", 0, 1, 8'hBF, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus("drain2", 0, 0, 8'h00, 1, 0);
    applyStimulus("rw_empty", 0, 1, 8'hC0, 1, 0);
    applyStimulus("drain3",   0, 0, 8'h00, 1, 1);
    applyStimulus("clr2",     0, 0, 8'h00, 0, 1);

    // registered-read sequence: two words, two reads, then idle
    applyStimulus("reg_wr", 0, 1, 8'h11, 0, 0);
    applyStimulus("reg_wr", 0, 1, 8'h22, 0, 0);
    applyStimulus("reg_rd", 0, 0, 8'h00, 1, 0);
    applyStimulus("reg_rd", 0, 0, 8'h00, 1, 0);
    applyStimulus("reg_hold", 0, 0, 8'h00, 0, 0);
    applyStimulus("reg_hold", 0, 0, 8'h00, 0, 0);

    // wrap: 13 writes with reads keeping occupancy in 2..4
    writes = 0;
    for (int cyc = 0; cyc < 60 && (writes < 13 || model_q.size() > 0); cyc++) begin
      w  = (writes < 13) && (model_q.size() < 4);
      rd = (model_q.size() >= 2) || (writes >= 13);
      if (w) writes++;
      applyStimulus("wrap", 0, w, 8'(8'h30 + writes), rd, 0);
    end

    // reset with three words queued; stale data must not come back
    for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 0, 1, 8'(8'hD0 + i), 0, 0);
    applyStimulus("mid_rst", 1, 0, 8'h00, 0, 0);
    applyStimulus("post_rst", 0, 0, 8'h00, 1, 0);
    applyStimulus("post_rst", 0, 1, 8'hE7, 0, 1);
    applyStimulus("post_rst", 0, 0, 8'h00, 1, 0);
    applyStimulus("post_rst", 0, 0, 8'h00, 1, 0);

    // randomized traffic with occasional error clears and resets
    for (int cyc = 0; cyc < 600; cyc++) begin
      applyStimulus("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                    8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
